// File: rtl/bank_req_arbiter.sv
// bank_req_arbiter: round-robin arbiter over NUM_REQ request FIFOs feeding one shared SRAM bank.
// Optional BANK_SPARE_ROW_EN adds a single spare word that can shadow one repaired address.
module bank_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int BANK_DEPTH = 256
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef BANK_SPARE_ROW_EN
    input  logic                      spare_en,
    input  logic [ADDR_W-1:0]         spare_addr,
`endif
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        nxt_gnt,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q, gnt_d, elig;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, win, cand;
    logic               found;
    logic               acc_vld_q, acc_vld_d, acc_we_q, acc_we_d;
    logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
    logic [ADDR_W-1:0]  acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0]  acc_wdata_q, acc_wdata_d;
    logic               rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               spare_hit;
    logic [DATA_W-1:0]  spare_rdata;
    logic [DATA_W-1:0]  mem [BANK_DEPTH];

    // A requester being popped this cycle still shows its old head, so it is masked out.
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = rr_ptr_q;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt_d       = found ? NUM_REQ'(1) << win : '0;
        rr_ptr_d    = found ? win : rr_ptr_q;
        acc_vld_d   = found;
        acc_we_d    = found ? req_we[win] : acc_we_q;
        acc_idx_d   = found ? win : acc_idx_q;
        acc_addr_d  = found ? req_addr[int'(win)*ADDR_W +: ADDR_W] : acc_addr_q;
        acc_wdata_d = found ? req_wdata[int'(win)*DATA_W +: DATA_W] : acc_wdata_q;
        rd_vld_d    = acc_vld_q && !acc_we_q;
        rd_idx_d    = acc_idx_q;
        rd_data_d   = rd_vld_d ? (spare_hit ? spare_rdata : mem[acc_addr_q]) : rd_data_q;
        rsp_vld_d   = rd_vld_q ? NUM_REQ'(1) << rd_idx_q : '0;
        rsp_data_d  = rd_vld_q ? rd_data_q : rsp_data_q;
    end

`ifdef BANK_SPARE_ROW_EN
    logic [DATA_W-1:0] spare_q, spare_d;
    assign spare_hit   = acc_vld_q && spare_en && (acc_addr_q == spare_addr);
    assign spare_rdata = spare_q;
    assign spare_d     = (spare_hit && acc_we_q) ? acc_wdata_q : spare_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) spare_q <= '0;
        else     spare_q <= spare_d;
    end
`else
    assign spare_hit   = 1'b0;
    assign spare_rdata = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            acc_vld_q   <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_idx_q   <= '0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            rd_data_q   <= '0;
            rsp_vld_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            acc_vld_q   <= acc_vld_d;
            acc_we_q    <= acc_we_d;
            acc_idx_q   <= acc_idx_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            rd_data_q   <= rd_data_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Array is not reset; an access killed by rst never commits because acc_vld_q clears asynchronously.
    always_ff @(posedge clk) begin
        if (acc_vld_q && acc_we_q && !spare_hit) mem[acc_addr_q] <= acc_wdata_q;
    end

    assign nxt_gnt  = gnt_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign busy     = acc_vld_q;
endmodule
